booth_radix8_seq_mult: RTL

Iterative, parametrised radix-8 Booth multiplier. It is the sequential successor to the combinational radix-8 partial-product encoder. It supports configurable operand width, a per-transaction signed/unsigned mode, and a configurable number of Booth digits retired per cycle. Operands arrive and products leave over valid/ready handshakes, so the block drops into the datapath's multiply unit.

---
 rtl/booth_mult_pkg.sv | 34 +++
 rtl/booth_radix8_digit_sel.sv | 41 ++++
 rtl/booth_radix8_seq_mult.sv | 131 +++++++++++++
 3 files changed

// File: rtl/booth_mult_pkg.sv
// Shared types and helpers for the radix-8 Booth sequential multiplier.
// The digit encoding and the FSM state type live here so the datapath and digit selector agree on them.
package booth_mult_pkg;

    typedef enum logic [3:0] {
        BD_ZERO, BD_P1, BD_P2, BD_P3, BD_P4, BD_M1, BD_M2, BD_M3, BD_M4
    } booth_digit_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_PRECOMP, ST_ITER, ST_DONE
    } mult_state_e;

    // Window is {b[3i+2], b[3i+1], b[3i], b[3i-1]}; value = -4*b2 + 2*b1 + b0 + bm1.
    function automatic booth_digit_e booth_decode(input logic [3:0] win);
        booth_digit_e d;
        case (win)
            4'b0001, 4'b0010: d = BD_P1;
            4'b0011, 4'b0100: d = BD_P2;
            4'b0101, 4'b0110: d = BD_P3;
            4'b0111:          d = BD_P4;
            4'b1000:          d = BD_M4;
            4'b1001, 4'b1010: d = BD_M3;
            4'b1011, 4'b1100: d = BD_M2;
            4'b1101, 4'b1110: d = BD_M1;
            default:          d = BD_ZERO;
        endcase
        return d;
    endfunction

    function automatic int ndig(input int w);
        return (w + 3) / 3;
    endfunction

endpackage

// File: rtl/booth_radix8_digit_sel.sv
// Combinational selector turning one 4-bit Booth window into a signed multiple of A.
// Only 3A is a hard multiple; it arrives pre-computed from the datapath.
module booth_radix8_digit_sel
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]              window,
    input  logic [WIDTH:0]          a_ext,
    input  logic [WIDTH+2:0]        a3,
    output logic signed [WIDTH+3:0] multiple
);

    localparam logic [WIDTH+3:0] ONE = (WIDTH + 4)'(1);

    booth_digit_e     digit;
    logic [WIDTH+3:0] a1_w;
    logic [WIDTH+3:0] a3_w;
    logic [WIDTH+3:0] mag;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        digit = booth_decode(window);
        a1_w  = {{3{a_ext[WIDTH]}}, a_ext};
        a3_w  = {a3[WIDTH+2], a3};
        mag   = '0;
        case (digit)
            BD_P1, BD_M1: mag = a1_w;
            BD_P2, BD_M2: mag = a1_w << 1;
            BD_P3, BD_M3: mag = a3_w;
            BD_P4, BD_M4: mag = a1_w << 2;
            default:      mag = '0;
        endcase
        if (digit inside {BD_M1, BD_M2, BD_M3, BD_M4}) begin
            multiple = $signed(~mag + ONE);
        end else begin
            multiple = $signed(mag);
        end
    end

endmodule

// File: rtl/booth_radix8_seq_mult.sv
// Iterative radix-8 Booth multiplier with valid/ready handshakes on operands and product.
// Retires DIGITS_PER_CYCLE Booth digits per ITER cycle into a 2*WIDTH wrapping accumulator.
module booth_radix8_seq_mult
    import booth_mult_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int DIGITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int NDIG = ndig(WIDTH);
    localparam int BEXT = 3 * NDIG;
    localparam int IW   = $clog2(NDIG + DIGITS_PER_CYCLE + 1);

    if (WIDTH < 4) begin : g_bad_width
        $error("booth_radix8_seq_mult: WIDTH must be >= 4");
    end
    if (DIGITS_PER_CYCLE < 1 || DIGITS_PER_CYCLE > NDIG) begin : g_bad_digits
        $error("booth_radix8_seq_mult: DIGITS_PER_CYCLE must be in 1..NDIG");
    end

    mult_state_e             state, state_nxt;
    logic [WIDTH:0]          a_ext_q;
    logic [WIDTH+2:0]        a3_q;
    logic [BEXT:0]           b_win_q;   // b_ext with the implicit 0 below bit 0
    logic [2*WIDTH-1:0]      acc;
    logic [2*WIDTH-1:0]      product_q;
    logic [IW-1:0]           idx;
    logic [BEXT-1:0]         b_ext;
    logic [WIDTH+2:0]        a_x3;
    logic [2*WIDTH-1:0]      step_sum;
    logic                    last_iter;
    logic [3:0]              win  [DIGITS_PER_CYCLE];
    logic signed [WIDTH+3:0] mult [DIGITS_PER_CYCLE];

    assign b_ext     = {{(BEXT - WIDTH){is_signed & b[WIDTH-1]}}, b};
    assign a_x3      = {{2{a_ext_q[WIDTH]}}, a_ext_q};
    assign last_iter = (int'(idx) + DIGITS_PER_CYCLE) >= NDIG;

    // Digits past the top of b_ext are forced to a zero window.
    always_comb begin
        for (int k = 0; k < DIGITS_PER_CYCLE; k++) begin
            if (int'(idx) + k < NDIG) begin
                win[k] = 4'(b_win_q >> (3 * (int'(idx) + k)));
            end else begin
                win[k] = '0;
            end
        end
    end

    for (genvar k = 0; k < DIGITS_PER_CYCLE; k++) begin : g_dig
        booth_radix8_digit_sel #(.WIDTH(WIDTH)) u_sel (
            .window   (win[k]),
            .a_ext    (a_ext_q),
            .a3       (a3_q),
            .multiple (mult[k])
        );
    end

    always_comb begin
        step_sum = '0;
        for (int k = 0; k < DIGITS_PER_CYCLE; k++) begin
            step_sum = step_sum + ((2 * WIDTH)'(mult[k]) << (3 * (int'(idx) + k)));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (in_valid)  state_nxt = ST_PRECOMP;
            ST_PRECOMP:                state_nxt = ST_ITER;
            ST_ITER:    if (last_iter) state_nxt = ST_DONE;
            ST_DONE:    if (out_ready) state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
    end

    // NOTE: the datapath registers are all plain flops (no memory), so each gets a reset value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_ext_q   <= '0;
            a3_q      <= '0;
            b_win_q   <= '0;
            acc       <= '0;
            product_q <= '0;
            idx       <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    a_ext_q <= {is_signed & a[WIDTH-1], a};
                    b_win_q <= {b_ext, 1'b0};
                    acc     <= '0;
                    idx     <= '0;
                end
                ST_PRECOMP: a3_q <= a_x3 + (a_x3 << 1);
                ST_ITER: begin
                    acc <= acc + step_sum;
                    idx <= idx + IW'(DIGITS_PER_CYCLE);
                    if (last_iter) product_q <= acc + step_sum;
                end
                default: ;
            endcase
        end
    end

    assign product = product_q;

endmodule
